// File: rtl/regf_wb_arb_pkg.sv
// Shared types and sizes for the register-file write-back arbiter slice.
package regf_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wb_req_t;

endpackage

// File: rtl/regf_wb_arb_if.sv
// Write-back bus: requester valid/ready/payload plus the registered register-file write port.
interface regf_wb_arb_if #(
    parameter int NREQ = 3
);
    import regf_wb_arb_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [REG_ADDR_W*NREQ-1:0] req_waddr;
    logic [XLEN*NREQ-1:0]       req_wdata;
    logic                       regf_we;
    logic [REG_ADDR_W-1:0]      regf_waddr;
    logic [XLEN-1:0]            regf_wdata;

    modport master (
        output req_valid, req_waddr, req_wdata,
        input  req_ready, regf_we, regf_waddr, regf_wdata
    );

    modport slave (
        input  req_valid, req_waddr, req_wdata,
        output req_ready, regf_we, regf_waddr, regf_wdata
    );

endinterface

// File: rtl/regf_wb_arb_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant among requests, search starts at rr.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr;
    logic [PW-1:0] rr_next;
    logic          found;
    int            idx;

    // Grants are suppressed during reset so no requester sees a handshake.
    always_comb begin
        gnt     = '0;
        rr_next = rr;
        found   = 1'b0;
        idx     = 0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr) + k;
                if (idx >= N) idx = idx - N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    rr_next  = (idx == N - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr <= '0;
        else        rr <= rr_next;
    end

endmodule

// File: rtl/regf_wb_arb.sv
// Write-back arbiter and RAW scoreboard for the 32x32 register file.
// Scoreboard is built only when REGF_WB_SCOREBOARD_EN is defined.
module regf_wb_arb
    import regf_wb_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regf_wb_arb_if.slave          wb,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] chk_raddr0,
    input  logic [REG_ADDR_W-1:0] chk_raddr1,
    output logic                  chk_busy0,
    output logic                  chk_busy1
);

    logic [NREQ-1:0] gnt;
    wb_req_t         win;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wb.req_valid),
        .gnt   (gnt)
    );

    assign wb.req_ready = gnt;

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win.waddr = wb.req_waddr[REG_ADDR_W*i +: REG_ADDR_W];
                win.wdata = wb.req_wdata[XLEN*i +: XLEN];
            end
        end
    end

    // Writes to x0 are accepted from the requester but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.regf_we    <= 1'b0;
            wb.regf_waddr <= '0;
            wb.regf_wdata <= '0;
        end else if (|gnt) begin
            wb.regf_we    <= (win.waddr != '0);
            wb.regf_waddr <= win.waddr;
            wb.regf_wdata <= win.wdata;
        end else begin
            wb.regf_we    <= 1'b0;
        end
    end

`ifdef REGF_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Bit 0 is never set, so x0 always reads as free; set is applied after clear so it wins.
    always_comb begin
        busy_next = busy;
        if (wb.regf_we) busy_next[wb.regf_waddr] = 1'b0;
        if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    assign chk_busy0 = busy[chk_raddr0];
    assign chk_busy1 = busy[chk_raddr1];
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, chk_raddr0, chk_raddr1};
    assign chk_busy0 = 1'b0;
    assign chk_busy1 = 1'b0;
`endif

endmodule
